// File: rtl/rd_burst_pfifo_if.sv
// Handshake bundle of the read-burst FIFO: write side, downstream side, status and error flags.
interface rd_burst_pfifo_if #(
  parameter int DSIZE = 36,
  parameter int DEPTH = 512
);
  logic                     wr_en;
  logic [DSIZE-1:0]         wr_data;
  logic                     wr_last;
  logic                     ds_rdy;
  logic                     burst_vld;
  logic [DSIZE-1:0]         burst_rd_data;
  logic                     burst_start;
  logic                     burst_last;
  logic                     afull;
  logic                     full;
  logic [$clog2(DEPTH):0]   level;
  logic                     err_clr;
  logic                     err_bfifo_full;

  modport slave (
    input  wr_en, wr_data, wr_last, ds_rdy, err_clr,
    output burst_vld, burst_rd_data, burst_start, burst_last,
           afull, full, level, err_bfifo_full
  );

  modport master (
    output wr_en, wr_data, wr_last, ds_rdy, err_clr,
    input  burst_vld, burst_rd_data, burst_start, burst_last,
           afull, full, level, err_bfifo_full
  );
endinterface

// File: rtl/rd_burst_pfifo.sv
// FWFT burst FIFO for the DRAM read-return path; optionally holds data back until a full
// burst (or a burst closed by a wr_last tag) is buffered, and frames each burst for the consumer.
module rd_burst_pfifo #(
  parameter int DSIZE        = 36,
  parameter int DEPTH        = 512,
  parameter int AFULL_MARGIN = 16,
  parameter int BURST_LEN    = 16,
  parameter int BURST_MODE   = 1
) (
  input  logic            clk,
  input  logic            rst,
  rd_burst_pfifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AFULL = LW'(DEPTH - AFULL_MARGIN);
  localparam logic [LW-1:0] LVL_BURST = LW'(BURST_LEN);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  logic [DSIZE:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d, pend_last_q, pend_last_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  state_e          state_q, state_d;
  logic            err_q, err_d;
  logic [DSIZE:0]  head;
  logic            full, vld, at_end, push, pop;

  // Head is read straight from storage so it is visible the cycle after it was written.
  assign head   = mem[rd_ptr_q];
  assign full   = (level_q == LVL_FULL);
  assign at_end = head[DSIZE] | (beat_cnt_q == BEAT_LAST);
  assign push   = bus.wr_en & ~full;
  assign pop    = bus.ds_rdy & vld;

  always_comb begin
    vld = (level_q != '0);
    if (BURST_MODE != 0 && state_q == IDLE)
      vld = (level_q != '0) && ((level_q >= LVL_BURST) || (pend_last_q != '0));
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    beat_cnt_d  = beat_cnt_q;
    state_d     = state_q;
    err_d       = err_q;
    pend_last_d = pend_last_q + {{(LW-1){1'b0}}, push & bus.wr_last}
                              - {{(LW-1){1'b0}}, pop & head[DSIZE]};
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // A tagged head closes the burst early, otherwise the last beat does.
    if (pop) begin
      if (at_end) begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end else begin
        state_d    = ACTIVE;
        beat_cnt_d = beat_cnt_q + BW'(1);
      end
    end
    if (bus.wr_en & full)  err_d = 1'b1;
    else if (bus.err_clr)  err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pend_last_q <= '0;
      beat_cnt_q  <= '0;
      state_q     <= IDLE;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pend_last_q <= pend_last_d;
      beat_cnt_q  <= beat_cnt_d;
      state_q     <= state_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {bus.wr_last, bus.wr_data};
  end

  assign bus.burst_vld      = vld;
  assign bus.burst_rd_data  = head[DSIZE-1:0];
  assign bus.burst_start    = vld & (state_q == IDLE);
  assign bus.burst_last     = vld & at_end;
  assign bus.level          = level_q;
  assign bus.afull          = (level_q >= LVL_AFULL);
  assign bus.full           = full;
  assign bus.err_bfifo_full = err_q;
endmodule

// File: tb/tb_rd_burst_pfifo.sv
// Drives a plain-mode and a burst-mode FIFO with shared stimulus and compares both against a queue model.
module tb_rd_burst_pfifo;
  localparam int DW = 36, DEPTH = 8, AFM = 2, BL = 4, HN = 8192;

  logic clk = 1'b0, rst = 1'b1;
  logic wr_en = 1'b0, wr_last = 1'b0, ds_rdy = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] wr_data = '0;

  always #5 clk = ~clk;

  rd_burst_pfifo_if #(.DSIZE(DW), .DEPTH(DEPTH)) bus_p ();
  rd_burst_pfifo_if #(.DSIZE(DW), .DEPTH(DEPTH)) bus_b ();

  assign bus_p.wr_en = wr_en;  assign bus_p.wr_data = wr_data;  assign bus_p.wr_last = wr_last;
  assign bus_p.ds_rdy = ds_rdy; assign bus_p.err_clr = err_clr;
  assign bus_b.wr_en = wr_en;  assign bus_b.wr_data = wr_data;  assign bus_b.wr_last = wr_last;
  assign bus_b.ds_rdy = ds_rdy; assign bus_b.err_clr = err_clr;

  rd_burst_pfifo #(.DSIZE(DW), .DEPTH(DEPTH), .AFULL_MARGIN(AFM), .BURST_LEN(BL), .BURST_MODE(0))
    u_plain (.clk(clk), .rst(rst), .bus(bus_p));
  rd_burst_pfifo #(.DSIZE(DW), .DEPTH(DEPTH), .AFULL_MARGIN(AFM), .BURST_LEN(BL), .BURST_MODE(1))
    u_burst (.clk(clk), .rst(rst), .bus(bus_b));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: per mode, a list of stored {tag,data} words between hd and tl, plus burst position.
  logic [DW:0] hist [2][HN];
  int hd [2], tl [2], pos [2];
  bit in_b [2], err_m [2];

  function automatic int m_cnt(int m);
    return tl[m] - hd[m];
  endfunction

  function automatic bit m_vld(int m);
    if (m_cnt(m) == 0) return 1'b0;
    if (m == 0 || in_b[m] || m_cnt(m) >= BL) return 1'b1;
    for (int i = hd[m]; i < tl[m]; i++)
      if (hist[m][i][DW]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_end(int m);
    return hist[m][hd[m]][DW] || (pos[m] == BL - 1);
  endfunction

  task automatic mdl_update();
    for (int m = 0; m < 2; m++) begin
      bit v, fl;
      v  = m_vld(m);
      fl = (m_cnt(m) == DEPTH);
      if (rst) begin
        hd[m] = 0; tl[m] = 0; pos[m] = 0; in_b[m] = 1'b0; err_m[m] = 1'b0;
      end else begin
        if (wr_en && fl) err_m[m] = 1'b1;
        else if (err_clr) err_m[m] = 1'b0;
        if (ds_rdy && v) begin
          if (m_end(m)) begin in_b[m] = 1'b0; pos[m] = 0; end
          else begin in_b[m] = 1'b1; pos[m]++; end
          hd[m]++;
        end
        if (wr_en && !fl) begin
          hist[m][tl[m]] = {wr_last, wr_data};
          tl[m]++;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      logic v, s, l, af, fu, e;
      logic [3:0] lv;
      logic [DW-1:0] d;
      string p;
      p = (m == 0) ? "p" : "b";
      if (m == 0) {v, s, l, af, fu, e, lv, d} = {bus_p.burst_vld, bus_p.burst_start, bus_p.burst_last,
        bus_p.afull, bus_p.full, bus_p.err_bfifo_full, bus_p.level, bus_p.burst_rd_data};
      else        {v, s, l, af, fu, e, lv, d} = {bus_b.burst_vld, bus_b.burst_start, bus_b.burst_last,
        bus_b.afull, bus_b.full, bus_b.err_bfifo_full, bus_b.level, bus_b.burst_rd_data};
      chk({p, "_level"}, lv, m_cnt(m));
      chk({p, "_vld"},   v,  m_vld(m));
      chk({p, "_afull"}, af, m_cnt(m) >= DEPTH - AFM);
      chk({p, "_full"},  fu, m_cnt(m) == DEPTH);
      chk({p, "_err"},   e,  err_m[m]);
      if (m_vld(m)) begin
        chk({p, "_data"},  d, hist[m][hd[m]][DW-1:0]);
        chk({p, "_start"}, s, !in_b[m]);
        chk({p, "_last"},  l, m_end(m));
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    mdl_update();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    @(negedge clk);
    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_level", bus_p.level, 0);
    chk("rst_vld_b", bus_b.burst_vld, 0);
    ds_rdy = 1'b1;
    repeat (10) cyc();
    chk("idle_level", bus_p.level, 0);
    chk("idle_vld", bus_p.burst_vld, 0);

    // fill to full, then overflow
    ds_rdy = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = DW'(i);
      cyc();
      chk("fill_afull", bus_p.afull, i >= 6);
      chk("fill_full", bus_p.full, i == 8);
    end
    wr_data = DW'(9);
    cyc();
    chk("ovf_err", bus_p.err_bfifo_full, 1);
    chk("ovf_level", bus_p.level, 8);
    wr_en = 1'b0; ds_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_vld", bus_p.burst_vld, 1);
      chk("drain_data", bus_p.burst_rd_data, i);
      cyc();
    end
    chk("drained_level", bus_p.level, 0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("err_clr", bus_p.err_bfifo_full, 0);

    // full burst of BL words
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = DW'(16 + i);
      cyc();
      chk("bw_vld", bus_b.burst_vld, 0);
    end
    wr_data = DW'(19);
    cyc();
    wr_en = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk("bb_vld", bus_b.burst_vld, 1);
      chk("bb_start", bus_b.burst_start, b == 0);
      chk("bb_last", bus_b.burst_last, b == 3);
      cyc();
    end
    chk("bb_done", bus_b.burst_vld, 0);

    // tagged short burst
    wr_en = 1'b1; wr_data = DW'(32);
    cyc();
    chk("sb_wait", bus_b.burst_vld, 0);
    wr_data = DW'(33); wr_last = 1'b1;
    cyc();
    wr_en = 1'b0; wr_last = 1'b0;
    for (int b = 0; b < 2; b++) begin
      chk("sb_vld", bus_b.burst_vld, 1);
      chk("sb_start", bus_b.burst_start, b == 0);
      chk("sb_last", bus_b.burst_last, b == 1);
      cyc();
    end
    chk("sb_done", bus_b.burst_vld, 0);
    chk("sb_level", bus_b.level, 0);

    // steady push+pop at level 5, wraps the pointers
    ds_rdy = 1'b0; wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin wr_data = DW'(64 + i); cyc(); end
    ds_rdy = 1'b1;
    for (int i = 5; i < 25; i++) begin
      wr_data = DW'(64 + i);
      cyc();
      chk("ss_level_p", bus_p.level, 5);
      chk("ss_level_b", bus_b.level, 5);
      chk("ss_head", bus_p.burst_rd_data, 64 + i - 4);
    end
    wr_en = 1'b0;
    repeat (6) cyc();

    // reset in the middle of a burst
    rst = 1'b1; cyc(); rst = 1'b0;
    ds_rdy = 1'b0; wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin wr_data = DW'(128 + i); cyc(); end
    wr_en = 1'b0; ds_rdy = 1'b1;
    repeat (2) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mrst_vld", bus_b.burst_vld, 0);
    chk("mrst_level", bus_b.level, 0);
    ds_rdy = 1'b0; wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin wr_data = DW'(144 + i); cyc(); end
    wr_en = 1'b0;
    chk("refill_start", bus_b.burst_start, 1);
    chk("refill_data", bus_b.burst_rd_data, 144);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      wr_en   = ($urandom_range(0, 9) < 6);
      wr_data = {4'($urandom), 32'($urandom)};
      wr_last = ($urandom_range(0, 7) == 0);
      ds_rdy  = ($urandom_range(0, 9) < 7);
      err_clr = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 149) == 0);
      cyc();
    end
    rst = 1'b0; wr_en = 1'b0; ds_rdy = 1'b0; err_clr = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
